traffic_phase_sequencer: RTL and testbench

//  N-approach traffic signal sequencer. Generalises the fixed 4-way rotation to
//  NUM_DIR approaches, with these additions:
//   - demand-driven round-robin that skips approaches with no demand;
//   - a bounded count of green extensions;
//   - emergency preemption.
//  It sits between the loop-detector conditioning logic and the lamp drivers.

---
 rtl/traffic_phase_sequencer.sv | 161 ++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer.sv
// N-approach traffic signal sequencer: demand-driven round-robin greens with bounded
// extensions and emergency preemption. Lamp outputs are decoded from registered state only.
module traffic_phase_sequencer #(
  parameter int unsigned NUM_DIR     = 4,
  parameter int unsigned TW          = 5,
  parameter int unsigned GREEN_TIME  = 9,
  parameter int unsigned EXT_TIME    = 9,
  parameter int unsigned MAX_EXT     = 1,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIR-1:0]         demand,
  input  logic [NUM_DIR-1:0]         ext_req,
  input  logic [NUM_DIR-1:0]         emg_req,
  output logic [2*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] green_dir,
  output logic [1:0]                 phase,
  output logic                       emg_active,
  output logic                       idle
);

  localparam int unsigned DW = $clog2(NUM_DIR);
  localparam int unsigned EW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

  localparam logic [TW-1:0] GreenLoad  = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] ExtLoad    = TW'(EXT_TIME - 1);
  localparam logic [TW-1:0] YellowLoad = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AllRedLoad = TW'(ALLRED_TIME - 1);

  typedef enum logic [1:0] {
    StAllRed = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   dir_q, dir_d;
  logic [DW-1:0]   last_dir_q, last_dir_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [EW-1:0]   ext_cnt_q, ext_cnt_d;

  logic            emg_any;
  logic [DW-1:0]   emg_dir;
  logic            rr_hit;
  logic [DW-1:0]   rr_dir;
  logic [DW-1:0]   rr_cand [NUM_DIR];
  logic            timer_zero;

  assign emg_any    = |emg_req;
  assign timer_zero = (timer_q == '0);

  // Lowest-index emergency request wins.
  always_comb begin
    emg_dir = '0;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (emg_req[i]) emg_dir = DW'(i);
    end
  end

  // Candidate order for the round-robin search: last_dir+1, last_dir+2, ... wrapping.
  always_comb begin
    for (int k = 0; k < NUM_DIR; k++) begin
      rr_cand[k] = DW'((32'(last_dir_q) + 32'(k) + 32'd1) % NUM_DIR);
    end
  end

  always_comb begin
    rr_hit = 1'b0;
    rr_dir = '0;
    for (int k = 0; k < NUM_DIR; k++) begin
      if (!rr_hit && demand[rr_cand[k]]) begin
        rr_hit = 1'b1;
        rr_dir = rr_cand[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    timer_d    = timer_q;
    ext_cnt_d  = ext_cnt_q;
    unique case (state_q)
      StAllRed: begin
        if (!timer_zero) begin
          timer_d = timer_q - TW'(1);
        end else if (emg_any || rr_hit) begin
          state_d    = StGreen;
          dir_d      = emg_any ? emg_dir : rr_dir;
          last_dir_d = emg_any ? emg_dir : rr_dir;
          timer_d    = GreenLoad;
          ext_cnt_d  = '0;
        end
      end
      StGreen: begin
        if (emg_req[dir_q]) begin
          // Preempting approach already has green: freeze until released.
          timer_d = timer_q;
        end else if (emg_any) begin
          state_d = StYellow;
          timer_d = YellowLoad;
        end else if (!timer_zero) begin
          timer_d = timer_q - TW'(1);
        end else if (ext_req[dir_q] && (32'(ext_cnt_q) < MAX_EXT)) begin
          timer_d   = ExtLoad;
          ext_cnt_d = ext_cnt_q + EW'(1);
        end else begin
          state_d = StYellow;
          timer_d = YellowLoad;
        end
      end
      StYellow: begin
        if (!timer_zero) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = StAllRed;
          timer_d = AllRedLoad;
        end
      end
      default: begin
        state_d = StAllRed;
        timer_d = AllRedLoad;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAllRed;
      dir_q      <= '0;
      last_dir_q <= DW'(NUM_DIR - 1);
      timer_q    <= AllRedLoad;
      ext_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      timer_q    <= timer_d;
      ext_cnt_q  <= ext_cnt_d;
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (dir_q == DW'(i)) begin
        if (state_q == StGreen)  lights[2*i +: 2] = 2'b10;
        if (state_q == StYellow) lights[2*i +: 2] = 2'b01;
      end
    end
  end

  assign green_dir  = dir_q;
  assign phase      = state_q;
  assign emg_active = emg_any;
  assign idle       = (state_q == StAllRed) && timer_zero && !(|demand) && !emg_any;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with default parameters; outputs sampled
// on the falling edge, expected values hand-derived from the cycle timeline.
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] demand;
  logic [3:0] ext_req;
  logic [3:0] emg_req;
  logic [7:0] lights;
  logic [1:0] green_dir;
  logic [1:0] phase;
  logic       emg_active;
  logic       idle;

  int checks = 0;
  int errors = 0;

  traffic_phase_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .demand     (demand),
    .ext_req    (ext_req),
    .emg_req    (emg_req),
    .lights     (lights),
    .green_dir  (green_dir),
    .phase      (phase),
    .emg_active (emg_active),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the falling edge at which rst is released (edge 0).
  task automatic start(input logic [3:0] dem, input logic [3:0] ext, input logic [3:0] emg);
    rst     = 1'b1;
    demand  = dem;
    ext_req = ext;
    emg_req = emg;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; demand = '0; ext_req = '0; emg_req = '0;
    #3;
    checks++; if (lights !== 8'h00) begin errors++;
      $display("FAIL reset_lights got %h want 00", lights); end
    checks++; if (phase !== 2'b00) begin errors++;
      $display("FAIL reset_phase got %b want 00", phase); end
    checks++; if (green_dir !== 2'd0) begin errors++;
      $display("FAIL reset_green_dir got %0d want 0", green_dir); end
    checks++; if (idle !== 1'b0) begin errors++;
      $display("FAIL reset_idle got %b want 0", idle); end
    checks++; if (emg_active !== 1'b0) begin errors++;
      $display("FAIL reset_emg_active got %b want 0", emg_active); end
    emg_req = 4'b0010;
    #1;
    checks++; if (emg_active !== 1'b1) begin errors++;
      $display("FAIL emg_active_comb got %b want 1", emg_active); end
    emg_req = '0;
  endtask

  task automatic test_rotation();
    logic [7:0] want_g, want_y;
    int d;
    start(4'b1111, 4'b0000, 4'b0000);
    step(1);
    checks++; if (phase !== 2'b00) begin errors++;
      $display("FAIL rot_initial_allred got %b want 00", phase); end
    step(1);
    for (int k = 0; k < 5; k++) begin
      d = k % 4;
      want_g = 8'h02 << (2 * d);
      want_y = 8'h01 << (2 * d);
      checks++; if (phase !== 2'b01 || green_dir !== 2'(d) || lights !== want_g) begin errors++;
        $display("FAIL rot_green_start k=%0d got phase=%b dir=%0d lights=%h want 01/%0d/%h",
                 k, phase, green_dir, lights, d, want_g); end
      step(8);
      checks++; if (phase !== 2'b01) begin errors++;
        $display("FAIL rot_green_end k=%0d got %b want 01", k, phase); end
      step(1);
      checks++; if (phase !== 2'b10 || lights !== want_y) begin errors++;
        $display("FAIL rot_yellow k=%0d got %b/%h want 10/%h", k, phase, lights, want_y); end
      step(2);
      checks++; if (phase !== 2'b00 || lights !== 8'h00) begin errors++;
        $display("FAIL rot_allred k=%0d got %b/%h want 00/00", k, phase, lights); end
      step(2);
    end
  endtask

  task automatic test_skip();
    int d;
    start(4'b0101, 4'b0000, 4'b0000);
    step(2);
    for (int k = 0; k < 4; k++) begin
      d = (k % 2) * 2;
      checks++; if (phase !== 2'b01 || green_dir !== 2'(d)) begin errors++;
        $display("FAIL skip_green k=%0d got %b/%0d want 01/%0d", k, phase, green_dir, d); end
      for (int c = 0; c < 13; c++) begin
        step(1);
        checks++; if (lights[3:2] !== 2'b00 || lights[7:6] !== 2'b00) begin errors++;
          $display("FAIL skip_unserved_red k=%0d c=%0d got lights=%h want [3:2],[7:6]=0",
                   k, c, lights); end
      end
    end
  endtask

  task automatic test_extension();
    start(4'b0001, 4'b0001, 4'b0000);
    step(11);
    checks++; if (phase !== 2'b01) begin errors++;
      $display("FAIL ext_extended got %b want 01", phase); end
    step(8);
    checks++; if (phase !== 2'b01) begin errors++;
      $display("FAIL ext_last_green got %b want 01", phase); end
    step(1);
    checks++; if (phase !== 2'b10 || lights !== 8'h01) begin errors++;
      $display("FAIL ext_yellow got %b/%h want 10/01", phase, lights); end
    step(4);
    checks++; if (phase !== 2'b01 || green_dir !== 2'd0) begin errors++;
      $display("FAIL ext_regreen got %b/%0d want 01/0", phase, green_dir); end
    step(17);
    checks++; if (phase !== 2'b01) begin errors++;
      $display("FAIL ext_regreen_last got %b want 01", phase); end
    step(1);
    checks++; if (phase !== 2'b10) begin errors++;
      $display("FAIL ext_regreen_yellow got %b want 10", phase); end
  endtask

  task automatic test_preempt();
    start(4'b0001, 4'b0000, 4'b0000);
    step(4);
    checks++; if (phase !== 2'b01 || green_dir !== 2'd0) begin errors++;
      $display("FAIL emg_pre got %b/%0d want 01/0", phase, green_dir); end
    emg_req = 4'b0100;
    step(1);
    checks++; if (phase !== 2'b10 || green_dir !== 2'd0 || lights !== 8'h01) begin errors++;
      $display("FAIL emg_truncate got %b/%0d/%h want 10/0/01", phase, green_dir, lights); end
    step(2);
    checks++; if (phase !== 2'b00) begin errors++;
      $display("FAIL emg_allred1 got %b want 00", phase); end
    step(1);
    checks++; if (phase !== 2'b00) begin errors++;
      $display("FAIL emg_allred2 got %b want 00", phase); end
    step(1);
    checks++; if (phase !== 2'b01 || green_dir !== 2'd2 || lights !== 8'h20) begin errors++;
      $display("FAIL emg_green got %b/%0d/%h want 01/2/20", phase, green_dir, lights); end
    step(20);
    checks++; if (phase !== 2'b01 || green_dir !== 2'd2) begin errors++;
      $display("FAIL emg_hold got %b/%0d want 01/2", phase, green_dir); end
    emg_req = 4'b0000;
    step(8);
    checks++; if (phase !== 2'b01) begin errors++;
      $display("FAIL emg_resume_green got %b want 01", phase); end
    step(1);
    checks++; if (phase !== 2'b10 || green_dir !== 2'd2) begin errors++;
      $display("FAIL emg_resume_yellow got %b/%0d want 10/2", phase, green_dir); end
  endtask

  task automatic test_idle();
    start(4'b0000, 4'b0000, 4'b0000);
    step(2);
    checks++; if (phase !== 2'b00 || idle !== 1'b1 || lights !== 8'h00) begin errors++;
      $display("FAIL idle_early got %b/%b/%h want 00/1/00", phase, idle, lights); end
    step(18);
    checks++; if (phase !== 2'b00 || idle !== 1'b1 || lights !== 8'h00) begin errors++;
      $display("FAIL idle_late got %b/%b/%h want 00/1/00", phase, idle, lights); end
    demand = 4'b1000;
    #1;
    checks++; if (idle !== 1'b0) begin errors++;
      $display("FAIL idle_drop got %b want 0", idle); end
    step(1);
    checks++; if (phase !== 2'b01 || green_dir !== 2'd3 || lights !== 8'h80) begin errors++;
      $display("FAIL idle_wake got %b/%0d/%h want 01/3/80", phase, green_dir, lights); end
  endtask

  task automatic test_async_reset();
    start(4'b1111, 4'b0000, 4'b0000);
    step(11);
    checks++; if (phase !== 2'b10 || lights !== 8'h01) begin errors++;
      $display("FAIL arst_pre got %b/%h want 10/01", phase, lights); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (lights !== 8'h00 || phase !== 2'b00) begin errors++;
      $display("FAIL arst_immediate got %h/%b want 00/00", lights, phase); end
    @(negedge clk);
    rst = 1'b0;
    step(1);
    checks++; if (phase !== 2'b00) begin errors++;
      $display("FAIL arst_allred got %b want 00", phase); end
    step(1);
    checks++; if (phase !== 2'b01 || green_dir !== 2'd0 || lights !== 8'h02) begin errors++;
      $display("FAIL arst_restart got %b/%0d/%h want 01/0/02", phase, green_dir, lights); end
  endtask

  initial begin
    rst = 1'b1; demand = '0; ext_req = '0; emg_req = '0;
    test_reset();
    test_rotation();
    test_skip();
    test_extension();
    test_preempt();
    test_idle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
